// File: rtl/audio_filter_ctrl_if.sv
// rtl/audio_filter_ctrl_if.sv - coefficient ROM read bus between the sequencer and the preset ROM
interface audio_filter_ctrl_if;
    logic [6:0]  rom_addr;
    logic        rom_rd;
    logic [39:0] rom_data;

    modport master (
        output rom_addr,
        output rom_rd,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  rom_rd,
        output rom_data
    );
endinterface

// File: rtl/audio_filter_ctrl.sv
// rtl/audio_filter_ctrl.sv - click-free audio filter preset sequencer (fade-out, ROM load, flush, fade-in)
module audio_filter_ctrl #(
    parameter int         RAMP_DIV  = 256,
    parameter int         FLUSH_CYC = 16,
    parameter logic [4:0] MUTE_ATT  = 5'd16
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    audio_filter_ctrl_if.master        rom_if,
    input  logic [3:0]                 i_afilter_sw,
    input  logic                       i_load_req,
    input  logic [3:0]                 i_vol_att,
    output logic [4:0]                 o_att,
    output logic                       o_flt_reset,
    output logic                       o_busy,
    output logic [31:0]                o_aflt_rate,
    output logic [39:0]                o_acx,
    output logic [7:0]                 o_acx0,
    output logic [7:0]                 o_acx1,
    output logic [7:0]                 o_acx2,
    output logic [23:0]                o_acy0,
    output logic [23:0]                o_acy1,
    output logic [23:0]                o_acy2
);

    localparam int RW = $clog2(RAMP_DIV);
    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam logic [RW-1:0] RAMP_RELOAD  = RW'(RAMP_DIV - 1);
    localparam logic [FW-1:0] FLUSH_RELOAD = FW'(FLUSH_CYC - 1);

    // Power-on coefficient set, used until the first preset load completes
    localparam logic [31:0] DEF_RATE = 32'd14112000;
    localparam logic [39:0] DEF_ACX  = 40'd480934;
    localparam logic [7:0]  DEF_ACX0 = 8'd3;
    localparam logic [7:0]  DEF_ACX1 = 8'd3;
    localparam logic [7:0]  DEF_ACX2 = 8'd1;
    localparam logic [23:0] DEF_ACY0 = -24'd6254107;
    localparam logic [23:0] DEF_ACY1 = 24'd6217090;
    localparam logic [23:0] DEF_ACY2 = -24'd2060133;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FADE_OUT,
        S_LOAD,
        S_FLUSH,
        S_FADE_IN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [3:0]      r_active_sw;
    logic [3:0]      r_target;
    logic [3:0]      r_idx;
    logic [RW-1:0]   r_ramp_cnt;
    logic [FW-1:0]   r_flush_cnt;
    logic [4:0]      r_att;
    logic            r_flt_reset;
    logic            r_busy;
    logic            r_rom_rd;
    logic [6:0]      r_rom_addr;

    // Shadow set: filled word by word, never visible on the outputs until complete
    logic [31:0]     r_sh_rate;
    logic [39:0]     r_sh_acx;
    logic [7:0]      r_sh_acx0, r_sh_acx1, r_sh_acx2;
    logic [23:0]     r_sh_acy0, r_sh_acy1, r_sh_acy2;

    logic [31:0]     r_aflt_rate;
    logic [39:0]     r_acx;
    logic [7:0]      r_acx0, r_acx1, r_acx2;
    logic [23:0]     r_acy0, r_acy1, r_acy2;

    logic [4:0]      w_vol_tgt;
    logic            w_ramp_exp;
    logic            w_sw_change;
    logic            w_att_muted;
    logic            w_load_last;
    logic [2:0]      w_cap_word;

    assign w_vol_tgt   = {1'b0, i_vol_att};
    assign w_ramp_exp  = (r_ramp_cnt == '0);
    assign w_sw_change = (i_afilter_sw != r_active_sw) || i_load_req;
    assign w_att_muted = (r_att >= MUTE_ATT);
    assign w_load_last = (r_idx == 4'd8);
    // ROM data returned in LOAD cycle n belongs to the word issued in cycle n-1
    assign w_cap_word  = r_idx[2:0] - 3'd1;

    // Next-state decode of the fade/load/flush sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_sw_change)            w_state_nxt = S_FADE_OUT;
            S_FADE_OUT: if (w_att_muted)            w_state_nxt = S_LOAD;
            S_LOAD:     if (w_load_last)            w_state_nxt = S_FLUSH;
            S_FLUSH:    if (r_flush_cnt == '0)      w_state_nxt = S_FADE_IN;
            S_FADE_IN:  if (r_att <= w_vol_tgt)     w_state_nxt = S_IDLE;
            default:                                w_state_nxt = S_FADE_OUT;
        endcase
    end

    // State register; reset lands in FADE_OUT already muted so a load starts right away
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_FADE_OUT;
        else         r_state <= w_state_nxt;
    end

    // Attenuation ramp, ROM addressing, flush timing and status flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_att       <= MUTE_ATT;
            r_ramp_cnt  <= RAMP_RELOAD;
            r_flush_cnt <= FLUSH_RELOAD;
            r_active_sw <= 4'd0;
            r_target    <= 4'd0;
            r_idx       <= 4'd0;
            r_flt_reset <= 1'b0;
            r_rom_rd    <= 1'b0;
            r_rom_addr  <= 7'd0;
            r_busy      <= 1'b1;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_att <= w_vol_tgt;
                    if (w_sw_change) r_ramp_cnt <= RAMP_RELOAD;
                end
                S_FADE_OUT: begin
                    if (w_att_muted) begin
                        // Preset is latched here, so late switch changes during the fade are absorbed
                        r_att      <= MUTE_ATT;
                        r_target   <= i_afilter_sw;
                        r_idx      <= 4'd0;
                        r_rom_rd   <= 1'b1;
                        r_rom_addr <= {i_afilter_sw, 3'd0};
                    end else if (w_ramp_exp) begin
                        r_att      <= r_att + 5'd1;
                        r_ramp_cnt <= RAMP_RELOAD;
                    end else begin
                        r_ramp_cnt <= r_ramp_cnt - RW'(1);
                    end
                end
                S_LOAD: begin
                    r_idx <= r_idx + 4'd1;
                    if (r_idx < 4'd7) begin
                        r_rom_rd   <= 1'b1;
                        r_rom_addr <= {r_target, r_idx[2:0] + 3'd1};
                    end else begin
                        r_rom_rd <= 1'b0;
                    end
                    if (w_load_last) begin
                        r_active_sw <= r_target;
                        r_flt_reset <= 1'b1;
                        r_flush_cnt <= FLUSH_RELOAD;
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_flt_reset <= 1'b0;
                        r_ramp_cnt  <= RAMP_RELOAD;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FW'(1);
                    end
                end
                S_FADE_IN: begin
                    if (r_att <= w_vol_tgt) begin
                        r_att <= w_vol_tgt;
                    end else if (w_ramp_exp) begin
                        r_att      <= r_att - 5'd1;
                        r_ramp_cnt <= RAMP_RELOAD;
                    end else begin
                        r_ramp_cnt <= r_ramp_cnt - RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture returned ROM words into the shadow set, truncating each to its field width
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh_rate <= DEF_RATE;
            r_sh_acx  <= DEF_ACX;
            r_sh_acx0 <= DEF_ACX0;
            r_sh_acx1 <= DEF_ACX1;
            r_sh_acx2 <= DEF_ACX2;
            r_sh_acy0 <= DEF_ACY0;
            r_sh_acy1 <= DEF_ACY1;
            r_sh_acy2 <= DEF_ACY2;
        end else if (r_state == S_LOAD && r_idx != 4'd0) begin
            case (w_cap_word)
                3'd0: r_sh_rate <= rom_if.rom_data[31:0];
                3'd1: r_sh_acx  <= rom_if.rom_data;
                3'd2: r_sh_acx0 <= rom_if.rom_data[7:0];
                3'd3: r_sh_acx1 <= rom_if.rom_data[7:0];
                3'd4: r_sh_acx2 <= rom_if.rom_data[7:0];
                3'd5: r_sh_acy0 <= rom_if.rom_data[23:0];
                3'd6: r_sh_acy1 <= rom_if.rom_data[23:0];
                default: r_sh_acy2 <= rom_if.rom_data[23:0];
            endcase
        end
    end

    // Commit the whole set in one edge; the last word bypasses the shadow since it arrives that same cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_aflt_rate <= DEF_RATE;
            r_acx       <= DEF_ACX;
            r_acx0      <= DEF_ACX0;
            r_acx1      <= DEF_ACX1;
            r_acx2      <= DEF_ACX2;
            r_acy0      <= DEF_ACY0;
            r_acy1      <= DEF_ACY1;
            r_acy2      <= DEF_ACY2;
        end else if (r_state == S_LOAD && w_load_last) begin
            r_aflt_rate <= r_sh_rate;
            r_acx       <= r_sh_acx;
            r_acx0      <= r_sh_acx0;
            r_acx1      <= r_sh_acx1;
            r_acx2      <= r_sh_acx2;
            r_acy0      <= r_sh_acy0;
            r_acy1      <= r_sh_acy1;
            r_acy2      <= rom_if.rom_data[23:0];
        end
    end

    assign rom_if.rom_addr = r_rom_addr;
    assign rom_if.rom_rd   = r_rom_rd;
    assign o_att           = r_att;
    assign o_flt_reset     = r_flt_reset;
    assign o_busy          = r_busy;
    assign o_aflt_rate     = r_aflt_rate;
    assign o_acx           = r_acx;
    assign o_acx0          = r_acx0;
    assign o_acx1          = r_acx1;
    assign o_acx2          = r_acx2;
    assign o_acy0          = r_acy0;
    assign o_acy1          = r_acy1;
    assign o_acy2          = r_acy2;

endmodule

// File: tb/tb_audio_filter_ctrl.sv
// tb/tb_audio_filter_ctrl.sv - directed self-checking bench for audio_filter_ctrl
module tb_audio_filter_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  afilter_sw = 4'd5;
    logic        load_req = 1'b0;
    logic [3:0]  vol_att = 4'd0;
    logic [4:0]  att;
    logic        flt_reset;
    logic        busy;
    logic [31:0] aflt_rate;
    logic [39:0] acx;
    logic [7:0]  acx0, acx1, acx2;
    logic [23:0] acy0, acy1, acy2;
    logic [167:0] coefs;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [167:0] DEF_COEFS = {32'd14112000, 40'd480934, 8'd3, 8'd3, 8'd1,
                                          24'hA091E5, 24'h5EDD82, 24'hE0909B};

    audio_filter_ctrl_if rom_if ();

    audio_filter_ctrl #(.RAMP_DIV(4), .FLUSH_CYC(16), .MUTE_ATT(5'd16)) u_dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .rom_if       (rom_if),
        .i_afilter_sw (afilter_sw),
        .i_load_req   (load_req),
        .i_vol_att    (vol_att),
        .o_att        (att),
        .o_flt_reset  (flt_reset),
        .o_busy       (busy),
        .o_aflt_rate  (aflt_rate),
        .o_acx        (acx),
        .o_acx0       (acx0),
        .o_acx1       (acx1),
        .o_acx2       (acx2),
        .o_acy0       (acy0),
        .o_acy1       (acy1),
        .o_acy2       (acy2)
    );

    assign coefs = {aflt_rate, acx, acx0, acx1, acx2, acy0, acy1, acy2};

    always #5 clk = ~clk;

    function automatic logic [39:0] rom_word(input logic [6:0] a);
        return {5{1'b0, a}};
    endfunction

    function automatic logic [167:0] exp_coefs(input logic [3:0] p);
        logic [39:0] w [8];
        for (int k = 0; k < 8; k++) w[k] = rom_word({p, 3'(k)});
        return {w[0][31:0], w[1], w[2][7:0], w[3][7:0], w[4][7:0],
                w[5][23:0], w[6][23:0], w[7][23:0]};
    endfunction

    // Registered ROM: data one cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        rom_if.rom_data <= rom_if.rom_rd ? rom_word(rom_if.rom_addr) : 40'hDEADBEEF5A;
    end

    // sel: 0 rom_rd high, 1 flt_reset high, 2 flt_reset low, 3 busy low
    task automatic wait_sig(input int sel, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            case (sel)
                0: ok = (rom_if.rom_rd === 1'b1);
                1: ok = (flt_reset === 1'b1);
                2: ok = (flt_reset === 1'b0);
                default: ok = (busy === 1'b0);
            endcase
            if (ok) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; afilter_sw = 4'd5; vol_att = 4'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (att !== 5'd16) begin n_bad++; $display("FAIL reset_att: got %0d want 16", att); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_cmp++; if (rom_if.rom_rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd: got %b want 0", rom_if.rom_rd); end
        n_cmp++; if (rom_if.rom_addr !== 7'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", rom_if.rom_addr); end
        n_cmp++; if (flt_reset !== 1'b0) begin n_bad++; $display("FAIL reset_flt: got %b want 0", flt_reset); end
        n_cmp++; if (coefs !== DEF_COEFS) begin n_bad++; $display("FAIL reset_coefs: got %h want %h", coefs, DEF_COEFS); end
    endtask

    task automatic test_reset_load();
        int cnt;
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (rom_if.rom_rd !== 1'b1 || rom_if.rom_addr !== 7'(40 + k)) begin
                n_bad++; $display("FAIL load_addr%0d: got rd=%b addr=%0d want rd=1 addr=%0d", k, rom_if.rom_rd, rom_if.rom_addr, 40 + k);
            end
            @(negedge clk);
        end
        n_cmp++; if (rom_if.rom_rd !== 1'b0) begin n_bad++; $display("FAIL load_rd_end: got %b want 0", rom_if.rom_rd); end
        n_cmp++; if (coefs !== DEF_COEFS) begin n_bad++; $display("FAIL load_no_partial: got %h want %h", coefs, DEF_COEFS); end
        @(negedge clk);
        n_cmp++; if (coefs !== exp_coefs(4'd5)) begin n_bad++; $display("FAIL load_commit5: got %h want %h", coefs, exp_coefs(4'd5)); end
        n_cmp++; if (flt_reset !== 1'b1) begin n_bad++; $display("FAIL load_flt_rise: got %b want 1", flt_reset); end
        cnt = 0;
        while (flt_reset === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
        n_cmp++; if (cnt != 16) begin n_bad++; $display("FAIL flush_len: got %0d want 16", cnt); end
        n_cmp++; if (att !== 5'd16) begin n_bad++; $display("FAIL fadein_start: got %0d want 16", att); end
        for (int j = 1; j <= 16; j++) begin
            repeat (4) @(negedge clk);
            n_cmp++; if (att !== 5'(16 - j)) begin n_bad++; $display("FAIL fadein_step%0d: got %0d want %0d", j, att, 16 - j); end
        end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fadein_busy: got %b want 1", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_preset_switch();
        bit ok;
        vol_att = 4'd8;
        @(negedge clk);
        n_cmp++; if (att !== 5'd8 || busy !== 1'b0) begin n_bad++; $display("FAIL sw_idle_att: got att=%0d busy=%b want 8/0", att, busy); end
        afilter_sw = 4'd2;
        @(negedge clk);
        n_cmp++; if (att !== 5'd8 || busy !== 1'b1) begin n_bad++; $display("FAIL sw_start: got att=%0d busy=%b want 8/1", att, busy); end
        repeat (31) @(negedge clk);
        n_cmp++; if (att !== 5'd15) begin n_bad++; $display("FAIL sw_fade31: got %0d want 15", att); end
        @(negedge clk);
        n_cmp++; if (att !== 5'd16) begin n_bad++; $display("FAIL sw_fade32: got %0d want 16", att); end
        @(negedge clk);
        n_cmp++; if (rom_if.rom_rd !== 1'b1 || rom_if.rom_addr !== 7'd16) begin n_bad++; $display("FAIL sw_load_addr: got rd=%b addr=%0d want 1/16", rom_if.rom_rd, rom_if.rom_addr); end
        wait_sig(1, 20, ok);
        n_cmp++; if (!ok || coefs !== exp_coefs(4'd2)) begin n_bad++; $display("FAIL sw_commit2: got %h want %h", coefs, exp_coefs(4'd2)); end
        wait_sig(3, 200, ok);
        n_cmp++; if (!ok || att !== 5'd8) begin n_bad++; $display("FAIL sw_return: got idle=%b att=%0d want 1/8", ok, att); end
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sw_settled: got busy=%b want 0", busy); end
    endtask

    task automatic test_mid_change();
        bit ok;
        afilter_sw = 4'd3;
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        afilter_sw = 4'd4;
        wait_sig(0, 100, ok);
        n_cmp++; if (!ok || rom_if.rom_addr !== 7'd32) begin n_bad++; $display("FAIL mid_addr4: got rd=%b addr=%0d want 1/32", ok, rom_if.rom_addr); end
        wait_sig(1, 20, ok);
        n_cmp++; if (!ok || coefs !== exp_coefs(4'd4)) begin n_bad++; $display("FAIL mid_commit4: got %h want %h", coefs, exp_coefs(4'd4)); end
        afilter_sw = 4'd7;
        wait_sig(2, 30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_flush_end: got timeout want flt_reset low"); end
        wait_sig(0, 300, ok);
        n_cmp++; if (!ok || rom_if.rom_addr !== 7'd56) begin n_bad++; $display("FAIL mid_addr7: got rd=%b addr=%0d want 1/56", ok, rom_if.rom_addr); end
        n_cmp++; if (coefs !== exp_coefs(4'd4)) begin n_bad++; $display("FAIL mid_hold4: got %h want %h", coefs, exp_coefs(4'd4)); end
        wait_sig(1, 20, ok);
        n_cmp++; if (!ok || coefs !== exp_coefs(4'd7)) begin n_bad++; $display("FAIL mid_commit7: got %h want %h", coefs, exp_coefs(4'd7)); end
        wait_sig(3, 200, ok);
        repeat (10) @(negedge clk);
        n_cmp++; if (!ok || busy !== 1'b0 || att !== 5'd8) begin n_bad++; $display("FAIL mid_settled: got idle=%b busy=%b att=%0d want 1/0/8", ok, busy, att); end
    endtask

    task automatic test_forced_reload();
        bit ok;
        vol_att = 4'd0;
        @(negedge clk);
        n_cmp++; if (att !== 5'd0) begin n_bad++; $display("FAIL frc_idle_att: got %0d want 0", att); end
        load_req = 1'b1; @(negedge clk); load_req = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL frc_start: got busy=%b want 1", busy); end
        repeat (10) @(negedge clk);
        load_req = 1'b1; @(negedge clk); load_req = 1'b0;
        wait_sig(0, 200, ok);
        n_cmp++; if (!ok || rom_if.rom_addr !== 7'd56) begin n_bad++; $display("FAIL frc_addr: got rd=%b addr=%0d want 1/56", ok, rom_if.rom_addr); end
        wait_sig(1, 20, ok);
        n_cmp++; if (!ok || coefs !== exp_coefs(4'd7)) begin n_bad++; $display("FAIL frc_commit: got %h want %h", coefs, exp_coefs(4'd7)); end
        wait_sig(3, 200, ok);
        repeat (10) @(negedge clk);
        n_cmp++; if (!ok || busy !== 1'b0 || att !== 5'd0) begin n_bad++; $display("FAIL frc_busy_drop: got idle=%b busy=%b att=%0d want 1/0/0", ok, busy, att); end
    endtask

    task automatic test_live_vol();
        bit ok;
        load_req = 1'b1; @(negedge clk); load_req = 1'b0;
        wait_sig(1, 200, ok);
        wait_sig(2, 30, ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (att === 5'd14) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL live_reach14: got att=%0d want 14", att); end
        vol_att = 4'd12;
        repeat (8) @(negedge clk);
        n_cmp++; if (att !== 5'd12 || busy !== 1'b1) begin n_bad++; $display("FAIL live_att12: got att=%0d busy=%b want 12/1", att, busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || att !== 5'd12) begin n_bad++; $display("FAIL live_idle: got busy=%b att=%0d want 0/12", busy, att); end
        repeat (5) @(negedge clk);
        n_cmp++; if (att !== 5'd12) begin n_bad++; $display("FAIL live_hold: got %0d want 12", att); end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        afilter_sw = 4'd1;
        wait_sig(0, 200, ok);
        n_cmp++; if (!ok || rom_if.rom_addr !== 7'd8) begin n_bad++; $display("FAIL rml_addr: got rd=%b addr=%0d want 1/8", ok, rom_if.rom_addr); end
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (coefs !== DEF_COEFS) begin n_bad++; $display("FAIL rml_defaults: got %h want %h", coefs, DEF_COEFS); end
        n_cmp++; if (rom_if.rom_rd !== 1'b0 || rom_if.rom_addr !== 7'd0) begin n_bad++; $display("FAIL rml_rd: got rd=%b addr=%0d want 0/0", rom_if.rom_rd, rom_if.rom_addr); end
        n_cmp++; if (att !== 5'd16 || busy !== 1'b1 || flt_reset !== 1'b0) begin n_bad++; $display("FAIL rml_state: got att=%0d busy=%b flt=%b want 16/1/0", att, busy, flt_reset); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (rom_if.rom_rd !== 1'b1 || rom_if.rom_addr !== 7'd8) begin n_bad++; $display("FAIL rml_reload: got rd=%b addr=%0d want 1/8", rom_if.rom_rd, rom_if.rom_addr); end
        wait_sig(1, 20, ok);
        n_cmp++; if (!ok || coefs !== exp_coefs(4'd1)) begin n_bad++; $display("FAIL rml_commit1: got %h want %h", coefs, exp_coefs(4'd1)); end
        wait_sig(3, 200, ok);
        n_cmp++; if (!ok || att !== 5'd12) begin n_bad++; $display("FAIL rml_final: got idle=%b att=%0d want 1/12", ok, att); end
    endtask

    initial begin
        test_reset();
        test_reset_load();
        test_preset_switch();
        test_mid_change();
        test_forced_reload();
        test_live_vol();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
